// File: rtl/sdram_init_monitor.sv
// ============================================================================
// Module  : sdram_init_monitor
// Brief   : Passive checker for the SDRAM power-up command stream (order,
//           spacing, MRS mode-word decode). Drives nothing on the SDRAM pins.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sdram_init_monitor #(
  parameter int POWERUP_CYC = 10000,
  parameter int T_RP        = 1,
  parameter int T_RC        = 4,
  parameter int NUM_AREF    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd,
  input  logic [12:0] addr,
  output logic        init_ok,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [2:0]  mode_bl,
  output logic        mode_bt,
  output logic [2:0]  mode_cl,
  output logic [3:0]  aref_cnt
);

  localparam int GAP_W = 14;
  localparam int PWR_W = $clog2(POWERUP_CYC + 1);

  localparam logic [GAP_W-1:0] c_gap_max  = '1;
  localparam logic [GAP_W-1:0] c_t_rp     = GAP_W'(T_RP);
  localparam logic [GAP_W-1:0] c_t_rc     = GAP_W'(T_RC);
  localparam logic [PWR_W-1:0] c_pwr_last = PWR_W'(POWERUP_CYC - 1);
  localparam logic [3:0]       c_num_aref = 4'(NUM_AREF);

  localparam logic [3:0] c_cmd_nop  = 4'b0111;
  localparam logic [3:0] c_cmd_pall = 4'b0010;
  localparam logic [3:0] c_cmd_aref = 4'b0001;
  localparam logic [3:0] c_cmd_mrs  = 4'b0000;

  localparam logic [2:0] c_err_early = 3'd1;
  localparam logic [2:0] c_err_order = 3'd2;
  localparam logic [2:0] c_err_a10   = 3'd3;
  localparam logic [2:0] c_err_trp   = 3'd4;
  localparam logic [2:0] c_err_trc   = 3'd5;
  localparam logic [2:0] c_err_mrs   = 3'd6;

  typedef enum logic [2:0] {
    S_WAIT_PWR  = 3'd0,
    S_WAIT_PALL = 3'd1,
    S_WAIT_AREF = 3'd2,
    S_READY     = 3'd3,
    S_ERROR     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PWR_W-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [3:0]         aref_cnt_q, aref_cnt_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [2:0]         mode_bl_q, mode_bl_d;
  logic               mode_bt_q, mode_bt_d;
  logic [2:0]         mode_cl_q, mode_cl_d;

  logic               w_is_cmd;
  logic               w_is_pall;
  logic               w_is_aref;
  logic               w_is_mrs;
  logic               w_mode_legal;
  logic [3:0]         w_aref_inc;
  logic               unused_addr;

  // Deselect (cs_n high) and NOP are both idle bus cycles.
  assign w_is_cmd  = !(cmd[3] || (cmd == c_cmd_nop));
  assign w_is_pall = (cmd == c_cmd_pall);
  assign w_is_aref = (cmd == c_cmd_aref);
  assign w_is_mrs  = (cmd == c_cmd_mrs);

  assign w_mode_legal = ((addr[2:0] <= 3'd3) || (addr[2:0] == 3'd7)) &&
                        ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3));

  assign w_aref_inc  = (aref_cnt_q == 4'hF) ? 4'hF : aref_cnt_q + 4'd1;
  assign unused_addr = ^{addr[12:11], addr[9:7]};

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    aref_cnt_d = aref_cnt_q;
    err_code_d = err_code_q;
    mode_bl_d  = mode_bl_q;
    mode_bt_d  = mode_bt_q;
    mode_cl_d  = mode_cl_q;

    if (w_is_cmd) begin
      gap_d = GAP_W'(1);
    end else if (gap_q != c_gap_max) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    case (state_q)
      S_WAIT_PWR: begin
        // A command in the expiry cycle still counts as early.
        if (w_is_cmd) begin
          state_d    = S_ERROR;
          err_code_d = c_err_early;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
          if (pwr_cnt_q == c_pwr_last) begin
            state_d = S_WAIT_PALL;
          end
        end
      end

      S_WAIT_PALL: begin
        if (w_is_cmd) begin
          if (!w_is_pall) begin
            state_d    = S_ERROR;
            err_code_d = c_err_order;
          end else if (!addr[10]) begin
            state_d    = S_ERROR;
            err_code_d = c_err_a10;
          end else begin
            state_d    = S_WAIT_AREF;
            aref_cnt_d = 4'd0;
          end
        end
      end

      S_WAIT_AREF: begin
        if (w_is_aref) begin
          if ((aref_cnt_q == 4'd0) && (gap_q < c_t_rp)) begin
            state_d    = S_ERROR;
            err_code_d = c_err_trp;
          end else if ((aref_cnt_q != 4'd0) && (gap_q < c_t_rc)) begin
            state_d    = S_ERROR;
            err_code_d = c_err_trc;
          end else begin
            aref_cnt_d = w_aref_inc;
          end
        end else if (w_is_mrs) begin
          if (aref_cnt_q < c_num_aref) begin
            state_d    = S_ERROR;
            err_code_d = c_err_order;
          end else if (gap_q < c_t_rc) begin
            state_d    = S_ERROR;
            err_code_d = c_err_trc;
          end else begin
            // Mode word is latched even when rejected, to aid debug.
            mode_bl_d = addr[2:0];
            mode_bt_d = addr[3];
            mode_cl_d = addr[6:4];
            if (w_mode_legal) begin
              state_d = S_READY;
            end else begin
              state_d    = S_ERROR;
              err_code_d = c_err_mrs;
            end
          end
        end else if (w_is_cmd) begin
          state_d    = S_ERROR;
          err_code_d = c_err_order;
        end
      end

      S_READY: begin
        if (w_is_pall) begin
          aref_cnt_d = 4'd0;
        end else if (w_is_aref) begin
          aref_cnt_d = w_aref_inc;
        end else if (w_is_mrs) begin
          mode_bl_d = addr[2:0];
          mode_bt_d = addr[3];
          mode_cl_d = addr[6:4];
          if (!w_mode_legal) begin
            state_d    = S_ERROR;
            err_code_d = c_err_mrs;
          end
        end
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_WAIT_PWR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT_PWR;
      pwr_cnt_q  <= '0;
      gap_q      <= '0;
      aref_cnt_q <= '0;
      err_code_q <= '0;
      mode_bl_q  <= '0;
      mode_bt_q  <= 1'b0;
      mode_cl_q  <= '0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      gap_q      <= gap_d;
      aref_cnt_q <= aref_cnt_d;
      err_code_q <= err_code_d;
      mode_bl_q  <= mode_bl_d;
      mode_bt_q  <= mode_bt_d;
      mode_cl_q  <= mode_cl_d;
    end
  end

  assign init_ok  = (state_q == S_READY);
  assign err      = (state_q == S_ERROR);
  assign err_code = err_code_q;
  assign mode_bl  = mode_bl_q;
  assign mode_bt  = mode_bt_q;
  assign mode_cl  = mode_cl_q;
  assign aref_cnt = aref_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_init_monitor.sv
// ============================================================================
// Module  : tb_sdram_init_monitor
// Brief   : Directed scoreboard bench for sdram_init_monitor.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sdram_init_monitor;

  localparam int P = 3000;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PALL = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cmd = NOP;
  logic [12:0] addr = '0;
  logic        init_ok, err, mode_bt;
  logic [2:0]  err_code, mode_bl, mode_cl;
  logic [3:0]  aref_cnt;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  sdram_init_monitor #(
    .POWERUP_CYC (P),
    .T_RP        (1),
    .T_RC        (4),
    .NUM_AREF    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .addr     (addr),
    .init_ok  (init_ok),
    .err      (err),
    .err_code (err_code),
    .mode_bl  (mode_bl),
    .mode_bt  (mode_bt),
    .mode_cl  (mode_cl),
    .aref_cnt (aref_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic ok, input logic e, input logic [2:0] code,
                                     input logic [2:0] bl, input logic bt, input logic [2:0] cl,
                                     input logic [3:0] ac);
    return {ok, e, code, bl, bt, cl, ac};
  endfunction

  task automatic compare();
    exp_t        x;
    logic [15:0] obs;
    obs = {init_ok, err, err_code, mode_bl, mode_bt, mode_cl, aref_cnt};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Drive one command for one sample edge and check the registered result.
  task automatic send(input logic [3:0] c, input logic [12:0] a, input string tag,
                      input logic [15:0] e);
    cmd  = c;
    addr = a;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    cmd  = NOP;
    addr = '0;
    compare();
  endtask

  task automatic check_now(input string tag, input logic [15:0] e);
    sb.push_back('{tag, e});
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous assert checked before any clock edge, released after one edge.
  task automatic do_reset(input string tag);
    cmd  = NOP;
    addr = '0;
    rst  = 1'b1;
    #1;
    check_now(tag, pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;

    // Legal init, then READY-state MRS re-decode
    do_reset("t1_reset");
    idle(P);
    send(PALL, 13'h400, "t1_pall", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t1_aref1", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd1));
    idle(4);
    send(AREF, 13'h000, "t1_aref2", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd2));
    idle(8);
    send(MRS, 13'h032, "t1_mrs", pk(1, 0, 3'd0, 3'd2, 0, 3'd3, 4'd2));
    idle(2);
    send(MRS, 13'h027, "t1_remrs", pk(1, 0, 3'd0, 3'd7, 0, 3'd2, 4'd2));
    send(AREF, 13'h000, "t1_ready_aref", pk(1, 0, 3'd0, 3'd7, 0, 3'd2, 4'd3));
    send(MRS, 13'h014, "t1_ready_badmrs", pk(0, 1, 3'd6, 3'd4, 0, 3'd1, 4'd3));
    send(PALL, 13'h400, "t1_err_frozen", pk(0, 1, 3'd6, 3'd4, 0, 3'd1, 4'd3));

    // Early command mid power-up, and on the last power-up cycle
    do_reset("t2_reset");
    idle(P / 2);
    send(PALL, 13'h400, "t2_early", pk(0, 1, 3'd1, 3'd0, 0, 3'd0, 4'd0));
    idle(P);
    send(PALL, 13'h400, "t2_sticky", pk(0, 1, 3'd1, 3'd0, 0, 3'd0, 4'd0));
    do_reset("t2b_reset");
    idle(P - 1);
    send(PALL, 13'h400, "t2b_edge_early", pk(0, 1, 3'd1, 3'd0, 0, 3'd0, 4'd0));

    // tRC violation between AREFs
    do_reset("t3_reset");
    idle(P);
    send(PALL, 13'h400, "t3_pall", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t3_aref1", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd1));
    idle(2);
    send(AREF, 13'h000, "t3_trc", pk(0, 1, 3'd5, 3'd0, 0, 3'd0, 4'd1));

    // PALL without A10; later legal commands keep code 3
    do_reset("t4_reset");
    idle(P);
    send(PALL, 13'h000, "t4_a10", pk(0, 1, 3'd3, 3'd0, 0, 3'd0, 4'd0));
    send(PALL, 13'h400, "t4_keep_pall", pk(0, 1, 3'd3, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t4_keep_aref", pk(0, 1, 3'd3, 3'd0, 0, 3'd0, 4'd0));

    // MRS with too few AREFs
    do_reset("t5_reset");
    idle(P);
    send(PALL, 13'h400, "t5_pall", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t5_aref1", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd1));
    idle(3);
    send(MRS, 13'h032, "t5_order", pk(0, 1, 3'd2, 3'd0, 0, 3'd0, 4'd1));

    // Minimum legal spacing, then illegal CAS latency
    do_reset("t6_reset");
    idle(P);
    send(PALL, 13'h400, "t6_pall", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t6_aref1", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd1));
    idle(3);
    send(AREF, 13'h000, "t6_aref2_trc_min", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd2));
    idle(3);
    send(MRS, 13'h052, "t6_badcl", pk(0, 1, 3'd6, 3'd2, 0, 3'd5, 4'd2));

    // AREF before PALL
    do_reset("t8_reset");
    idle(P);
    send(AREF, 13'h000, "t8_order", pk(0, 1, 3'd2, 3'd0, 0, 3'd0, 4'd0));

    // Reset mid-sequence, then full legal sequence
    do_reset("t7_reset");
    idle(P);
    send(PALL, 13'h400, "t7_pall", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t7_aref1", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd1));
    do_reset("t7_midreset");
    idle(P);
    send(PALL, 13'h400, "t7_pall2", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd0));
    send(AREF, 13'h000, "t7_aref1b", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd1));
    idle(4);
    send(AREF, 13'h000, "t7_aref2b", pk(0, 0, 3'd0, 3'd0, 0, 3'd0, 4'd2));
    idle(8);
    send(MRS, 13'h032, "t7_ready", pk(1, 0, 3'd0, 3'd2, 0, 3'd3, 4'd2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
